misr_test_controller: RTL
=========================

# misr_test_controller

Hardware initiator for the MISR control/status register port. On a start pulse it runs one compaction sequence on the register bus:
- programs the coefficients;
- clears the MISR, then enables it for a programmed number of cycles;
- freezes it and reads back the signature;
- compares the signature against a golden value and reports pass/fail.

It sits between the self-test sequencing logic and the MISR wrapper's `re`/`we`/`addr`/`data` port. Upstream of this block, an external mux gives it sole ownership of that port while `busy_o` is high.

## Interface
- `NBIT_DATA`, 64: register/data width.
- `NBIT_ADDR`, 64: register address width.
- `NBIT_REGS`, 64: register width; offsets are multiples of `NBIT_REGS/8`.
- `START_ADDR`, 2**25: MISR register base address.
- `NBIT_LEN`, 32: compaction length width.
- `READ_WAIT`, 1: idle cycles between freeze and signature read (0..15).

Ports:
- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset. Synchronous, active-high.
- `start_i` in 1: start request. Sampled in IDLE only.
- `abort_i` in 1: abort request. Sampled in any non-IDLE state.
- `len_i` in `NBIT_LEN`: number of compaction cycles. Latched on start.
- `coeff_i` in `NBIT_REGS`: MISR feedback coefficients. Latched on start.
- `golden_i` in `NBIT_DATA`: expected signature. Latched on start.
- `busy_o` out 1: high in every state except IDLE.
- `active_o` out 1: high exactly in cycles where the MISR enable bit is driven to 1.
- `done_o` out 1: one-cycle completion pulse.
- `pass_o` out 1: signature matches golden. Valid from `done_o` onward, held until the next start.
- `aborted_o` out 1: last run was aborted. Held until the next start.
- `signature_o` out `NBIT_DATA`: last signature read. Held until the next start.
- `re_o`, `we_o` out 1: register read/write strobes. Never both high.
- `addr_o` out `NBIT_ADDR`: register address. 0 when no access is in progress.
- `data_o` out `NBIT_REGS`: register write data. 0 when no write is in progress.
- `data_i` in `NBIT_DATA`: register read data. Combinational response, same cycle as `re_o`.

## Operation
Register map:
- CTRL at `START_ADDR`. Bit 0 = enable; bit 1 = run/not-reset, where 0 holds the MISR in reset.
- COEFF at `START_ADDR+NBIT_REGS/8`.
- SIG at `START_ADDR+2*NBIT_REGS/8` (read-only).

Control words:
- `CLEAR` = 0x0
- `RUN` = 0x3
- `HOLD` = 0x2

FSM states and bus activity:
- **IDLE**: no access. `start_i`=1 latches `len_i`, `coeff_i` and `golden_i`, clears `pass_o`, `aborted_o` and `signature_o`, and moves to WR_COEFF.
- **WR_COEFF**: `we_o`=1, addr=COEFF, data=coeff. Next: WR_CLR.
- **WR_CLR**: `we_o`=1, addr=CTRL, data=`CLEAR`. Next: WR_RUN.
- **WR_RUN**:
  - Normal case: `we_o`=1, addr=CTRL, data=`RUN`, `active_o`=1. The counter loads len-1. Next: RUN, or WR_STOP if len==1.
  - len==0: data=`HOLD`, `active_o`=0. Next: WR_STOP.
- **RUN**: no access (the CTRL register holds `RUN`). `active_o`=1; the counter decrements each cycle. Leaves to WR_STOP in the cycle the counter reads 1.
- **WR_STOP**: `we_o`=1, addr=CTRL, data=`HOLD`. Next: WAIT, or RD_SIG if `READ_WAIT`==0.
- **WAIT**: no access for `READ_WAIT` cycles. Next: RD_SIG.
- **RD_SIG**: `re_o`=1, addr=SIG. Registers `data_i` into `signature_o` and `pass_o`=(`data_i`==golden). Next: DONE.
- **DONE**: `done_o`=1. Next: IDLE.
- **WR_ABORT**: `we_o`=1, addr=CTRL, data=`CLEAR`. Sets `aborted_o`=1 and `pass_o`=0. Next: DONE.

Boundary conditions:
- **Abort**: `abort_i` in any state from WR_COEFF to RD_SIG goes to WR_ABORT next cycle. The current cycle's access still completes. Abort in DONE or IDLE is ignored.
- **`start_i` while busy**: ignored.
- **`start_i` and `abort_i` together in IDLE**: start is taken.
- **Latched inputs**: changes to `len_i`, `coeff_i` or `golden_i` mid-run have no effect.
- **len == 2^`NBIT_LEN`-1**: counter must not wrap; exactly len enabled cycles occur.
- **len==0**: zero enabled cycles; the expected signature is 0.

## Timing
- **Reset**: all outputs are 0 one cycle after `rst_i` is sampled high; state goes to IDLE; latched registers clear. Reset mid-run drops the bus access immediately and does not issue a CLEAR write.
- **Enable cycles**: `active_o` is high for exactly len consecutive cycles (WR_RUN plus len-1 RUN cycles). The wrapper's enable follows the CTRL write data combinationally, so this gives exactly len MISR enable cycles.
- **Start to done**: `done_o` rises len+5+`READ_WAIT` cycles after the edge sampling `start_i` (len≥1). For len==0 the delay is 6+`READ_WAIT`.
- **Next run**: a new `start_i` is accepted in the cycle after `done_o`.
- **Output registration**: all outputs are registered; `addr_o`, `data_o`, `we_o` and `re_o` are decoded from registered state only.

## Structure
- Package `misr_ctrl_pkg` holds:
  - the state enum `misr_ctrl_state_e`;
  - register offset localparams;
  - `ENABLE_BIT` = 0, `RESET_BIT` = 1;
  - control words `CTRL_CLEAR`, `CTRL_RUN`, `CTRL_HOLD`.
- Single module plus one sub-module, `misr_len_counter`: a loadable down-counter with a terminal flag, `NBIT_LEN` wide.

## Test plan
- **Basic run**: len=4, coeff=0x1B, base 0x2000000. Required bus trace:
  - we@0x2000008 data 0x1B
  - we@0x2000000 data 0
  - we@0x2000000 data 3
  - 3 idle cycles
  - we@0x2000000 data 2
  - 1 wait cycle
  - re@0x2000010
  - `done_o` at cycle 10
  - `active_o` high for exactly 4 cycles
- **Pass/fail**: bench MISR model with golden = model signature gives `pass_o`=1. Golden XOR 0x1 gives `pass_o`=0; `signature_o` equals the model value in both cases.
- **len=0 and len=1**:
  - len=0: WR_RUN writes 0x2, `active_o` never high, signature 0, pass if golden=0.
  - len=1: `active_o` high 1 cycle, RUN skipped.
- **Abort in RUN**: len=100, `abort_i` at RUN cycle 10. Required response:
  - next cycle: we@CTRL data 0
  - then `done_o`, `aborted_o`=1, `pass_o`=0
  - no read is issued
- **Protocol checks**: `start_i` held high through a whole run gives exactly one run, then a second run starts the cycle after `done_o`. `rst_i` in WR_RUN zeroes all outputs next cycle, and a fresh start then completes normally.

Source files
------------

// File: rtl/misr_ctrl_pkg.sv
// Shared definitions for the MISR test controller: FSM states, register map
// indices and the CTRL register control words.
package misr_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_COEFF,
        WR_CLR,
        WR_RUN,
        RUN,
        WR_STOP,
        WAIT,
        RD_SIG,
        DONE,
        WR_ABORT
    } misr_ctrl_state_e;

    // Register indices; byte offset is index * (NBIT_REGS/8)
    localparam int unsigned CTRL_IDX  = 0;
    localparam int unsigned COEFF_IDX = 1;
    localparam int unsigned SIG_IDX   = 2;

    // CTRL bit positions: enable, and run/not-reset (0 holds the MISR in reset)
    localparam int ENABLE_BIT = 0;
    localparam int RESET_BIT  = 1;

    localparam logic [1:0] CTRL_CLEAR = 2'b00;
    localparam logic [1:0] CTRL_HOLD  = 2'(1 << RESET_BIT);
    localparam logic [1:0] CTRL_RUN   = CTRL_HOLD | 2'(1 << ENABLE_BIT);

endpackage

// File: rtl/misr_test_controller_if.sv
// Register port between the test controller (master) and the MISR wrapper
// (slave). Read data is a combinational response to re.
interface misr_test_controller_if #(
    parameter int unsigned NBIT_DATA = 64,
    parameter int unsigned NBIT_ADDR = 64,
    parameter int unsigned NBIT_REGS = 64
);

    logic                 re;
    logic                 we;
    logic [NBIT_ADDR-1:0] addr;
    logic [NBIT_REGS-1:0] wdata;
    logic [NBIT_DATA-1:0] rdata;

    modport master (output re, output we, output addr, output wdata, input rdata);
    modport slave  (input re, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/misr_len_counter.sv
// Loadable down-counter used both for the compaction length and for the
// freeze-to-read wait; 'last' flags the final counted cycle.
module misr_len_counter #(
    parameter int unsigned NBIT_LEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load,
    input  logic [NBIT_LEN-1:0] load_value,
    input  logic                dec,
    output logic                last
);

    logic [NBIT_LEN-1:0] count;

    // Load has priority over decrement; never wraps in normal use
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - NBIT_LEN'(1);
        end
    end

    assign last = (count == NBIT_LEN'(1));

endmodule

// File: rtl/misr_test_controller.sv
// Runs one MISR compaction sequence over the register port per start pulse:
// program coefficients, clear, enable for len cycles, freeze, read the
// signature and compare it against the latched golden value.
module misr_test_controller
    import misr_ctrl_pkg::*;
#(
    parameter int unsigned          NBIT_DATA  = 64,
    parameter int unsigned          NBIT_ADDR  = 64,
    parameter int unsigned          NBIT_REGS  = 64,
    parameter logic [NBIT_ADDR-1:0] START_ADDR = NBIT_ADDR'(2**25),
    parameter int unsigned          NBIT_LEN   = 32,
    parameter int unsigned          READ_WAIT  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NBIT_LEN-1:0]  len_i,
    input  logic [NBIT_REGS-1:0] coeff_i,
    input  logic [NBIT_DATA-1:0] golden_i,
    output logic                 busy_o,
    output logic                 active_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 aborted_o,
    output logic [NBIT_DATA-1:0] signature_o,
    misr_test_controller_if.master bus
);

    localparam logic [NBIT_ADDR-1:0] CTRL_ADDR  = START_ADDR + NBIT_ADDR'(CTRL_IDX * (NBIT_REGS / 8));
    localparam logic [NBIT_ADDR-1:0] COEFF_ADDR = START_ADDR + NBIT_ADDR'(COEFF_IDX * (NBIT_REGS / 8));
    localparam logic [NBIT_ADDR-1:0] SIG_ADDR   = START_ADDR + NBIT_ADDR'(SIG_IDX * (NBIT_REGS / 8));

    misr_ctrl_state_e     state_q, state_d;
    logic [NBIT_LEN-1:0]  len_q;
    logic [NBIT_REGS-1:0] coeff_q;
    logic [NBIT_DATA-1:0] golden_q;
    logic                 pass_q;
    logic                 aborted_q;
    logic [NBIT_DATA-1:0] signature_q;
    logic                 len_zero;
    logic                 cnt_load;
    logic [NBIT_LEN-1:0]  cnt_value;
    logic                 cnt_dec;
    logic                 cnt_last;
    logic                 abort_window;

    assign len_zero = (len_q == '0);

    // The same counter times the RUN phase (loaded len-1) and the WAIT phase
    assign cnt_load  = (state_q == WR_RUN) || (state_q == WR_STOP);
    assign cnt_value = (state_q == WR_RUN) ? (len_q - NBIT_LEN'(1)) : NBIT_LEN'(READ_WAIT);
    assign cnt_dec   = (state_q == RUN) || (state_q == WAIT);

    misr_len_counter #(.NBIT_LEN(NBIT_LEN)) u_len_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .last       (cnt_last)
    );

    assign abort_window = (state_q != IDLE) && (state_q != DONE) && (state_q != WR_ABORT);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides any normal transition in its window
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_i) state_d = WR_COEFF;
            WR_COEFF: state_d = WR_CLR;
            WR_CLR:   state_d = WR_RUN;
            WR_RUN:   state_d = (len_q <= NBIT_LEN'(1)) ? WR_STOP : RUN;
            RUN:      if (cnt_last) state_d = WR_STOP;
            WR_STOP:  state_d = (READ_WAIT == 0) ? RD_SIG : WAIT;
            WAIT:     if (cnt_last) state_d = RD_SIG;
            RD_SIG:   state_d = DONE;
            DONE:     state_d = IDLE;
            WR_ABORT: state_d = DONE;
            default:  state_d = IDLE;
        endcase
        if (abort_i && abort_window) begin
            state_d = WR_ABORT;
        end
    end

    // Bus strobes, address and write data decoded from the registered state
    always_comb begin
        bus.we    = 1'b0;
        bus.re    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        unique case (state_q)
            WR_COEFF: begin
                bus.we    = 1'b1;
                bus.addr  = COEFF_ADDR;
                bus.wdata = coeff_q;
            end
            WR_CLR, WR_ABORT: begin
                bus.we    = 1'b1;
                bus.addr  = CTRL_ADDR;
                bus.wdata = NBIT_REGS'(CTRL_CLEAR);
            end
            WR_RUN: begin
                bus.we    = 1'b1;
                bus.addr  = CTRL_ADDR;
                bus.wdata = len_zero ? NBIT_REGS'(CTRL_HOLD) : NBIT_REGS'(CTRL_RUN);
            end
            WR_STOP: begin
                bus.we    = 1'b1;
                bus.addr  = CTRL_ADDR;
                bus.wdata = NBIT_REGS'(CTRL_HOLD);
            end
            RD_SIG: begin
                bus.re   = 1'b1;
                bus.addr = SIG_ADDR;
            end
            default: begin
            end
        endcase
    end

    // Latch run parameters on start and capture the result/abort status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q       <= '0;
            coeff_q     <= '0;
            golden_q    <= '0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
            signature_q <= '0;
        end else begin
            if (state_q == IDLE && start_i) begin
                len_q       <= len_i;
                coeff_q     <= coeff_i;
                golden_q    <= golden_i;
                pass_q      <= 1'b0;
                aborted_q   <= 1'b0;
                signature_q <= '0;
            end
            if (state_q == RD_SIG) begin
                signature_q <= bus.rdata;
                pass_q      <= (bus.rdata == golden_q);
            end
            if (state_q == WR_ABORT) begin
                aborted_q <= 1'b1;
                pass_q    <= 1'b0;
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign active_o    = ((state_q == WR_RUN) && !len_zero) || (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign pass_o      = pass_q;
    assign aborted_o   = aborted_q;
    assign signature_o = signature_q;

endmodule
